// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared constants for the VGA calculator display path: glyph geometry,
// ROM row-index width, colour width, sync idle level and active area size.
// No ports.
// ---------------------------------------------------------------------------
package display_pkg;

  localparam int GLYPH_W   = 5;
  localparam int GLYPH_H   = 5;
  localparam int ROW_IDX_W = 3;
  localparam int RGB_W     = 8;

  // Level of hsync/vsync while no sync pulse is being generated
  localparam logic SYNC_IDLE = 1'b1;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

endpackage

// File: rtl/glyph_renderer_if.sv
// ---------------------------------------------------------------------------
// glyph_renderer_if
// Bundles the beam/sync inputs, the glyph ROM handshake and the coloured
// pixel outputs of the glyph renderer.
//   master : timing generator + ROM side (drives beam, syncs, rom_code)
//   slave  : the renderer (drives rom_row, pixel_on, rgb, delayed syncs)
// ---------------------------------------------------------------------------
interface glyph_renderer_if;
  import display_pkg::*;

  logic                 pix_en;
  logic                 video_on;
  logic [9:0]           hcount;
  logic [9:0]           vcount;
  logic                 hsync_in;
  logic                 vsync_in;
  logic [ROW_IDX_W-1:0] rom_row;
  logic [GLYPH_W-1:0]   rom_code;
  logic                 pixel_on;
  logic [RGB_W-1:0]     rgb;
  logic                 hsync_out;
  logic                 vsync_out;
  logic                 video_on_out;

  modport master (
    output pix_en, video_on, hcount, vcount, hsync_in, vsync_in, rom_code,
    input  rom_row, pixel_on, rgb, hsync_out, vsync_out, video_on_out
  );

  modport slave (
    input  pix_en, video_on, hcount, vcount, hsync_in, vsync_in, rom_code,
    output rom_row, pixel_on, rgb, hsync_out, vsync_out, video_on_out
  );

endinterface

// File: rtl/glyph_renderer_sync_delay.sv
// ---------------------------------------------------------------------------
// sync_delay_line
// N-stage shift register that advances only on en, used to keep the
// hsync/vsync/video_on bundle aligned with the glyph pixel pipeline.
// Every stage resets to RESET_VAL (the idle level of each bit).
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : shift enable (one pixel tick)
//   din          : bundle entering stage 0
//   dout         : bundle leaving the last stage
// ---------------------------------------------------------------------------
module sync_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (en) begin
      stage_d[0] = din;
      for (int i = 1; i < STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/glyph_renderer.sv
// ---------------------------------------------------------------------------
// glyph_renderer
// Draws one 5x5 glyph, magnified by 2^SCALE_LOG2, in a fixed box whose
// top-left corner is (X0, Y0). Two pixel-tick pipeline:
//   stage 1 : box test, glyph column/row, drives rom_row
//   stage 2 : picks the column bit of rom_code -> dot, colour output
// The syncs and video_on are delayed by the same two ticks.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : beam coordinates, syncs, ROM row/code, pixel/colour out
// Optional build macro GLYPH_BLINK_EN: a 6-bit vsync falling-edge frame
// counter blanks the glyph while its bit 5 is set (32 on / 32 off frames).
// ---------------------------------------------------------------------------
module glyph_renderer
  import display_pkg::*;
#(
  parameter logic [9:0]       X0         = 10'd300,
  parameter logic [9:0]       Y0         = 10'd220,
  parameter int               SCALE_LOG2 = 2,
  parameter logic [RGB_W-1:0] FG_RGB     = 8'hFF,
  parameter logic [RGB_W-1:0] BG_RGB     = 8'h00
) (
  input  logic              clk,
  input  logic              reset_n,
  glyph_renderer_if.slave   bus
);

  localparam logic [10:0] BOX_W = 11'(GLYPH_W << SCALE_LOG2);
  localparam logic [10:0] BOX_H = 11'(GLYPH_H << SCALE_LOG2);

  logic [10:0]          dx;
  logic [10:0]          dy;
  logic                 in_box;
  logic                 in_box_q, in_box_d;
  logic [2:0]           col_q, col_d;
  logic [ROW_IDX_W-1:0] row_q, row_d;
  logic                 dot_q, dot_d;
  logic                 col_bit;
  logic                 blank;
  logic [2:0]           sync_out;

  // 11-bit offsets: a beam left of / above the box shows up as bit 10 set,
  // so a box clipped by the screen edge never wraps around
  always_comb begin
    dx     = {1'b0, bus.hcount} - {1'b0, X0};
    dy     = {1'b0, bus.vcount} - {1'b0, Y0};
    in_box = bus.video_on & ~dx[10] & ~dy[10] & (dx < BOX_W) & (dy < BOX_H);
  end

  always_comb begin
    in_box_d = in_box_q;
    col_d    = col_q;
    row_d    = row_q;
    if (bus.pix_en) begin
      in_box_d = in_box;
      col_d    = 3'(dx >> SCALE_LOG2);
      row_d    = ROW_IDX_W'(dy >> SCALE_LOG2);
    end
  end

  // Bit 4 of the row code is the leftmost dot; columns past 4 yield no dot
  always_comb begin
    col_bit = 1'b0;
    case (col_q)
      3'd0:    col_bit = bus.rom_code[4];
      3'd1:    col_bit = bus.rom_code[3];
      3'd2:    col_bit = bus.rom_code[2];
      3'd3:    col_bit = bus.rom_code[1];
      3'd4:    col_bit = bus.rom_code[0];
      default: col_bit = 1'b0;
    endcase
  end

`ifdef GLYPH_BLINK_EN
  logic       vsync_prev_q, vsync_prev_d;
  logic [5:0] frame_cnt_q, frame_cnt_d;

  // Count vsync falling edges, sampled on pixel ticks
  always_comb begin
    vsync_prev_d = vsync_prev_q;
    frame_cnt_d  = frame_cnt_q;
    if (bus.pix_en) begin
      vsync_prev_d = bus.vsync_in;
      if (vsync_prev_q && !bus.vsync_in) begin
        frame_cnt_d = frame_cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_prev_q <= SYNC_IDLE;
      frame_cnt_q  <= 6'd0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign blank = frame_cnt_q[5];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    dot_d = dot_q;
    if (bus.pix_en) begin
      dot_d = in_box_q & col_bit & ~blank;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_box_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      dot_q    <= 1'b0;
    end else begin
      in_box_q <= in_box_d;
      col_q    <= col_d;
      row_q    <= row_d;
      dot_q    <= dot_d;
    end
  end

  // Bundle order {hsync, vsync, video_on}
  sync_delay_line #(
    .WIDTH     (3),
    .STAGES    (2),
    .RESET_VAL ({SYNC_IDLE, SYNC_IDLE, 1'b0})
  ) u_sync_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (bus.pix_en),
    .din     ({bus.hsync_in, bus.vsync_in, bus.video_on}),
    .dout    (sync_out)
  );

  assign bus.rom_row      = row_q;
  assign bus.pixel_on     = dot_q;
  assign bus.hsync_out    = sync_out[2];
  assign bus.vsync_out    = sync_out[1];
  assign bus.video_on_out = sync_out[0];

  always_comb begin
    bus.rgb = '0;
    if (sync_out[0]) begin
      bus.rgb = dot_q ? FG_RGB : BG_RGB;
    end
  end

endmodule

// File: tb/tb_glyph_renderer.sv
// ---------------------------------------------------------------------------
// tb_glyph_renderer
// Drives glyph_renderer with directed beam/sync vectors against a sign-glyph
// ROM. A reference model predicts each output from the glyph geometry and
// a two-tick latency queue; a compare process checks every cycle, and a set
// of hand-computed literal expectations pins the model.
// ---------------------------------------------------------------------------
module tb_glyph_renderer;

  logic clk;
  logic reset_n;

  glyph_renderer_if bus ();

  glyph_renderer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Sign glyph rows
  logic [4:0] glyph [5];
  initial begin
    glyph[0] = 5'b00100;
    glyph[1] = 5'b01110;
    glyph[2] = 5'b00100;
    glyph[3] = 5'b00000;
    glyph[4] = 5'b01110;
  end

  // Combinational ROM: rows beyond the glyph read as blank
  always_comb begin
    bus.rom_code = 5'b00000;
    if (bus.rom_row < 3'd5) bus.rom_code = glyph[bus.rom_row];
  end

  typedef struct {
    logic [7:0] rgb;
    logic       pix;
    logic       hs;
    logic       vs;
    logic       vid;
  } exp_t;

  exp_t expQ[$];
  int   modelFrames;
  logic modelPrevVs;

  // Expected dot from screen position: 20x20 box at (300,220), 4x4 dots
  function automatic logic glyphDot(int h, int v, logic vid, int frames);
    int r;
    int c;
    if (!vid) return 1'b0;
    if (h < 300 || h >= 320 || v < 220 || v >= 240) return 1'b0;
`ifdef GLYPH_BLINK_EN
    if (((frames / 32) % 2) == 1) return 1'b0;
`endif
    r = (v - 220) / 4;
    c = (h - 300) / 4;
    return ((glyph[r] >> (4 - c)) & 5'd1) != 5'd0;
  endfunction

  // Reference model: each tick queues the prediction for the current beam;
  // the front of the queue is what the outputs show two ticks later
  always @(posedge clk) begin
    exp_t e;
    if (!reset_n) begin
      e.rgb = 8'h00; e.pix = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.vid = 1'b0;
      expQ = {};
      expQ.push_back(e);
      expQ.push_back(e);
      modelFrames = 0;
      modelPrevVs = 1'b1;
    end else if (bus.pix_en) begin
      e.pix = glyphDot(int'(bus.hcount), int'(bus.vcount), bus.video_on, modelFrames);
      e.rgb = (bus.video_on && e.pix) ? 8'hFF : 8'h00;
      e.hs  = bus.hsync_in;
      e.vs  = bus.vsync_in;
      e.vid = bus.video_on;
      expQ.push_back(e);
      void'(expQ.pop_front());
      if (modelPrevVs && !bus.vsync_in) modelFrames++;
      modelPrevVs = bus.vsync_in;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (reset_n && expQ.size() > 0) begin
      checks++;
      if (bus.rgb !== expQ[0].rgb || bus.pixel_on !== expQ[0].pix ||
          bus.hsync_out !== expQ[0].hs || bus.vsync_out !== expQ[0].vs ||
          bus.video_on_out !== expQ[0].vid) begin
        errors++;
        $display("[TB] FAIL stream t=%0t: got rgb=%h pix=%b hs=%b vs=%b vid=%b expected rgb=%h pix=%b hs=%b vs=%b vid=%b",
                 $time, bus.rgb, bus.pixel_on, bus.hsync_out, bus.vsync_out, bus.video_on_out,
                 expQ[0].rgb, expQ[0].pix, expQ[0].hs, expQ[0].vs, expQ[0].vid);
      end
    end
  end

  task automatic applyStimulus(input int h, input int v, input logic vid,
                               input logic hs, input logic vs, input logic en);
    @(posedge clk);
    #2;
    bus.hcount   = 10'(h);
    bus.vcount   = 10'(v);
    bus.video_on = vid;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    bus.pix_en   = en;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One in-video pixel followed by a filler; checks rom_row after the first
  // tick and rgb after the second
  task automatic pinPixel(input string name, input int h, input int v,
                          input int expRow, input int expRgb);
    applyStimulus(h, v, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput({name, "_row"}, 32'(bus.rom_row), 32'(expRow));
    @(posedge clk);
    #1;
    checkOutput({name, "_rgb"}, 32'(bus.rgb), 32'(expRgb));
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.pix_en   = 1'b0;
    bus.video_on = 1'b0;
    bus.hcount   = '0;
    bus.vcount   = '0;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Async reset during active video
    repeat (3) applyStimulus(308, 220, 1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_rgb", 32'(bus.rgb), 32'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("reset_rgb", 32'(bus.rgb), 32'h00);
    checkOutput("reset_pix", 32'(bus.pixel_on), 32'h0);
    checkOutput("reset_hs", 32'(bus.hsync_out), 32'h1);
    checkOutput("reset_vs", 32'(bus.vsync_out), 32'h1);
    checkOutput("reset_vid", 32'(bus.video_on_out), 32'h0);
    checkOutput("reset_row", 32'(bus.rom_row), 32'h0);
    @(posedge clk);
    #2;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    reset_n = 1'b1;

    // Hand-computed pins
    pinPixel("p308_220", 308, 220, 0, 8'hFF);
    pinPixel("p300_220", 300, 220, 0, 8'h00);
    pinPixel("p304_224", 304, 224, 1, 8'hFF);
    pinPixel("p312_236", 312, 236, 4, 8'hFF);
    pinPixel("p316_236", 316, 236, 4, 8'h00);
    pinPixel("p311_239", 311, 239, 4, 8'hFF);
    pinPixel("p320_220", 320, 220, 0, 8'h00);
    pinPixel("p308_240", 308, 240, 5, 8'h00);
    pinPixel("p296_220", 296, 220, 0, 8'h00);

    // Row 0 sweep and row 3 (all clear) sweep through the right edge
    for (int h = 296; h <= 312; h++) applyStimulus(h, 220, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int h = 298; h <= 322; h++) applyStimulus(h, 232, 1'b1, 1'b1, 1'b1, 1'b1);

    // Pixel enable 1-of-4 over a coordinate stream: outputs hold between ticks
    for (int i = 0; i < 12; i++) begin
      applyStimulus(298 + 2 * i, 228, 1'b1, i[0], 1'b1, 1'b1);
      repeat (3) applyStimulus(298 + 2 * i, 228, 1'b1, i[0], 1'b1, 1'b0);
    end

    // Blanked video inside the box; syncs pass through two ticks late
    applyStimulus(308, 220, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(308, 220, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("hs_one_tick", 32'(bus.hsync_out), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("hs_two_ticks", 32'(bus.hsync_out), 32'h0);
    checkOutput("blank_rgb", 32'(bus.rgb), 32'h00);
    checkOutput("blank_pix", 32'(bus.pixel_on), 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(304 + i, 224, 1'b0, i[1], i[2], 1'b1);

`ifdef GLYPH_BLINK_EN
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    end
    pinPixel("blink_off", 308, 220, 0, 8'h00);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    end
    pinPixel("blink_on", 308, 220, 0, 8'hFF);
`endif

    repeat (3) applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/glyph_renderer.md
Name: glyph_renderer

Overview:
- Downstream consumer of the 5x5 glyph row ROMs (e.g. the sign glyph) in the VGA calculator display path.
- Takes the current beam coordinates from VGA timing and drives the 3-bit row index into a glyph ROM.
- Registers the returned 5-bit row code, picks the column bit and outputs a pixel/colour.
- Delays the sync signals so they stay aligned with the colour output. Glyph is placed at a fixed box and magnified by a power of two.

Parameters:
- X0, 10'd300, left edge of glyph box (screen pixels)
- Y0, 10'd220, top edge of glyph box
- SCALE_LOG2, 2, magnification; each glyph dot is 2^SCALE_LOG2 square screen pixels
- FG_RGB, 8'hFF, colour for a set dot (RGB332)
- BG_RGB, 8'h00, colour inside video area for a clear dot or outside the box

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel-tick enable (one clk per VGA pixel); pipeline advances only when high
- video_on  in  1  beam in active area
- hcount  in  10  beam column
- vcount  in  10  beam row
- hsync_in  in  1  horizontal sync from timing generator
- vsync_in  in  1  vertical sync from timing generator
- rom_row  out  3  row index to glyph ROM (combinational ROM, same-cycle return)
- rom_code  in  5  row bit pattern from ROM; bit 4 = leftmost dot
- pixel_on  out  1  high when the current output pixel is a set glyph dot
- rgb  out  8  colour output
- hsync_out  out  1  hsync delayed to match rgb
- vsync_out  out  1  vsync delayed to match rgb
- video_on_out  out  1  video_on delayed to match rgb

Behaviour:
- Reset (async, reset_n=0): all pipeline registers clear; rom_row=0, pixel_on=0, rgb=0, hsync_out=1, vsync_out=1 (idle high), video_on_out=0.
- Box geometry: W = H = 5 << SCALE_LOG2. dx = hcount - X0, dy = vcount - Y0. Both are computed in 11 bits so that a negative result sets bit 10.
- in_box = video_on & ~dx[10] & ~dy[10] & (dx < W) & (dy < H).
- Stage 1 (on clk when pix_en): register in_box, col = dx >> SCALE_LOG2 (3 bits), row = dy >> SCALE_LOG2, and the three sync/video signals.
- rom_row is driven from the stage-1 row register, so it is stable for a whole pixel.
- Stage 2 (on clk when pix_en): register dot = in_box_s1 & rom_code[4 - col_s1], plus the syncs and video_on from stage 1.
- Outputs come from stage 2:
  - pixel_on = dot
  - rgb = !video_on_out ? 0 : (dot ? FG_RGB : BG_RGB)
- Latency: exactly 2 pix_en ticks from coordinate input to rgb and the delayed syncs. All outputs shift together.
- pix_en low: all registers hold and outputs are frozen.
- Boundaries:
  - col is never > 4 while in_box is 1. If col > 4, dot is forced to 0 (no out-of-range index).
  - Coordinates at X0+W or Y0+H are outside the box.
  - A box that is clipped by the screen edge renders only the visible part, with no wrap.
- Reset asserted mid-frame clears immediately. After release, the first valid output appears 2 pix_en ticks after the first enabled tick.

Optional Feature:
- Macro GLYPH_BLINK_EN.
- Defined:
  - A 6-bit frame counter increments on each vsync_in falling edge. The edge is detected with a registered copy of vsync_in, sampled on pix_en.
  - While counter bit 5 = 1, dot is forced to 0, so the glyph blinks with a 32-frame on / 32-frame off period.
  - The counter resets to 0 (glyph visible).
- Undefined: no counter; the glyph is always visible.

Decomposition:
- Shared package display_pkg:
  - GLYPH_W = 5, GLYPH_H = 5, ROW_IDX_W = 3
  - RGB width 8
  - sync idle level constant
  - the H/V active-area constants 640/480
- One natural sub-module: sync_delay_line, a parameterised N-stage enabled shift register for hsync/vsync/video_on, reset to idle.
- The bit-select logic stays inline.

Test Plan:
1. Reset with reset_n=0 during active video -> rgb=0, hsync_out=1, vsync_out=1, pixel_on=0 immediately, without waiting for clk.
2. ROM modelled as the sign glyph (rows 00100, 01110, 00100, 00000, 01110), defaults, scan vcount=220, hcount=308..311 -> rom_row=0, rgb=FF for those 4 pixels, 2 pix_en later; hcount=300..307 -> rgb=00.
3. vcount=232 (row 3, all clear), hcount 300..319 -> rgb=00 throughout; hcount=320 -> outside box, rgb=00.
4. Toggle pix_en 1-of-4 with a fixed coordinate stream -> output sequence identical to pix_en=1 case, only stretched; outputs constant between ticks.
5. video_on=0 inside box coordinates -> rgb=0 and pixel_on=0; syncs pass through delayed 2 ticks exactly.
6. With GLYPH_BLINK_EN: 32 vsync falling edges -> glyph dots read 00; after 64 edges -> glyph visible again.
